// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide engine for the EX stage.
// One operation is accepted per START; BUSY holds the pipeline while the
// engine iterates (one bit per cycle), DONE pulses for one cycle with a
// registered RESULT.
// Optional build macro MULDIV_FAST_MUL_EN: the four multiply ops use a
// single-cycle product and finish on the one-cycle special-case path;
// divides stay iterative.
//
// Handshake: START is sampled only while the FSM is in IDLE or DONE. An
// accepted START either finishes immediately (special cases, DONE in the
// next cycle) or enters CALC. DONE is high for exactly one cycle and RESULT
// holds until the next completion. FLUSH cancels anything at the next edge,
// wins over START, and never produces DONE.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic             FLUSH,
  input  logic [2:0]       SELECT,
  input  logic [WIDTH-1:0] DATA1,
  input  logic [WIDTH-1:0] DATA2,
  output logic [WIDTH-1:0] RESULT,
  output logic             BUSY,
  output logic             DONE,
  output logic [1:0]       DBG_STATE
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

`ifdef MULDIV_FAST_MUL_EN
  localparam logic FAST_MUL = 1'b1;
`else
  localparam logic FAST_MUL = 1'b0;
`endif

  state_t             r_state;
  state_t             w_state_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0] r_acc;     // mul: {partial hi, multiplier}; div: {remainder, quotient}
  logic [WIDTH-1:0]   r_mcand;   // multiplicand magnitude or divisor magnitude
  logic [2:0]         r_op;
  logic               r_neg;     // final result must be negated
  logic [WIDTH-1:0]   r_result;

  // Input-side decode, used only at the accept edge
  logic               w_in_div;
  logic               w_in_s1;
  logic               w_in_s2;
  logic               w_neg1;
  logic               w_neg2;
  logic [WIDTH-1:0]   w_mag1;
  logic [WIDTH-1:0]   w_mag2;
  logic               w_in_neg;
  logic               w_div_zero;
  logic               w_ovf;
  logic               w_accept;
  logic               w_special;
  logic [WIDTH-1:0]   w_special_val;
  logic [2*WIDTH-1:0] w_fast_prod;

  // Iteration datapath
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_next;
  logic [WIDTH:0]     w_div_shift;
  logic               w_div_ge;
  logic [WIDTH-1:0]   w_div_rem;
  logic [2*WIDTH-1:0] w_div_next;

  // Sign fix-up
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;
  logic [WIDTH-1:0]   w_fix_result;

  assign w_in_div = SELECT[2];
  // MUL is treated as signed: its low half is identical either way.
  assign w_in_s1  = w_in_div ? ~SELECT[0] : (SELECT[1:0] != 2'b11);
  assign w_in_s2  = w_in_div ? ~SELECT[0] : ~SELECT[1];
  assign w_neg1   = w_in_s1 & DATA1[WIDTH-1];
  assign w_neg2   = w_in_s2 & DATA2[WIDTH-1];
  assign w_mag1   = w_neg1 ? (~DATA1 + WIDTH'(1)) : DATA1;
  assign w_mag2   = w_neg2 ? (~DATA2 + WIDTH'(1)) : DATA2;
  // Remainder takes the dividend's sign; product and quotient take s1^s2.
  assign w_in_neg = (w_in_div & SELECT[1]) ? w_neg1 : (w_neg1 ^ w_neg2);

  assign w_div_zero = (DATA2 == '0);
  assign w_ovf      = ~SELECT[0] &
                      (DATA1 == {1'b1, {(WIDTH-1){1'b0}}}) &
                      (DATA2 == '1);

  assign w_accept = ((r_state == S_IDLE) || (r_state == S_DONE)) & START & ~FLUSH;

`ifdef MULDIV_FAST_MUL_EN
  logic [2*WIDTH-1:0] w_fast_a;
  logic [2*WIDTH-1:0] w_fast_b;
  assign w_fast_a    = {{WIDTH{w_in_s1 & DATA1[WIDTH-1]}}, DATA1};
  assign w_fast_b    = {{WIDTH{w_in_s2 & DATA2[WIDTH-1]}}, DATA2};
  assign w_fast_prod = w_fast_a * w_fast_b;
`else
  assign w_fast_prod = '0;
`endif

  // Results that need no iteration: divide by zero, signed overflow, fast mul
  always_comb begin
    w_special     = 1'b0;
    w_special_val = '0;
    if (w_in_div && w_div_zero) begin
      w_special     = 1'b1;
      w_special_val = SELECT[1] ? DATA1 : '1;
    end else if (w_in_div && w_ovf) begin
      w_special     = 1'b1;
      w_special_val = SELECT[1] ? '0 : DATA1;
    end else if (!w_in_div && FAST_MUL) begin
      w_special     = 1'b1;
      w_special_val = (SELECT[1:0] == 2'b00) ? w_fast_prod[WIDTH-1:0]
                                             : w_fast_prod[2*WIDTH-1:WIDTH];
    end
  end

  // Shift-add step: add multiplicand into the high half when LSB is set
  assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} +
                      (r_acc[0] ? {1'b0, r_mcand} : {(WIDTH+1){1'b0}});
  assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

  // Restoring division step: shift in next dividend bit, trial-subtract
  assign w_div_shift = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_div_ge    = (w_div_shift >= {1'b0, r_mcand});
  assign w_div_rem   = w_div_shift[WIDTH-1:0] - r_mcand;
  assign w_div_next  = w_div_ge ? {w_div_rem, r_acc[WIDTH-2:0], 1'b1}
                                : {w_div_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};

  // Apply recorded sign and pick the requested half/field
  assign w_prod = r_neg ? (~r_acc + (2*WIDTH)'(1)) : r_acc;
  assign w_quo  = r_neg ? (~r_acc[WIDTH-1:0] + WIDTH'(1)) : r_acc[WIDTH-1:0];
  assign w_rem  = r_neg ? (~r_acc[2*WIDTH-1:WIDTH] + WIDTH'(1)) : r_acc[2*WIDTH-1:WIDTH];

  always_comb begin
    w_fix_result = '0;
    if (r_op[2]) begin
      w_fix_result = r_op[1] ? w_rem : w_quo;
    end else if (r_op[1:0] == 2'b00) begin
      w_fix_result = w_prod[WIDTH-1:0];
    end else begin
      w_fix_result = w_prod[2*WIDTH-1:WIDTH];
    end
  end

  // State register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode; FLUSH overrides everything
  always_comb begin
    w_state_next = r_state;
    if (FLUSH) begin
      w_state_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (START) begin
            w_state_next = w_special ? S_DONE : S_CALC;
          end else begin
            w_state_next = S_IDLE;
          end
        end
        S_CALC: begin
          if (r_cnt == CNT_W'(WIDTH-1)) begin
            w_state_next = S_FIX;
          end
        end
        S_FIX:   w_state_next = S_DONE;
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  // Operand capture, iteration and result write
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_op     <= '0;
      r_neg    <= 1'b0;
      r_result <= '0;
    end else if (!FLUSH) begin
      if (w_accept) begin
        if (w_special) begin
          r_result <= w_special_val;
        end else begin
          r_op    <= SELECT;
          r_neg   <= w_in_neg;
          r_cnt   <= '0;
          r_mcand <= w_in_div ? w_mag2 : w_mag1;
          r_acc   <= {{WIDTH{1'b0}}, (w_in_div ? w_mag1 : w_mag2)};
        end
      end else if (r_state == S_CALC) begin
        r_cnt <= r_cnt + CNT_W'(1);
        r_acc <= r_op[2] ? w_div_next : w_mul_next;
      end else if (r_state == S_FIX) begin
        r_result <= w_fix_result;
      end
    end
  end

  assign RESULT    = r_result;
  assign BUSY      = (r_state == S_CALC) || (r_state == S_FIX);
  assign DONE      = (r_state == S_DONE);
  assign DBG_STATE = r_state;

endmodule
